output_port_fifo: RTL and testbench
===================================

Name: output_port_fifo

Overview:
- Downstream stage of the 16-bit multicycle processor's output register.
- Captures each value the processor emits on its output path into a small FIFO, then presents it to a slower consumer (display/UART/host driver) through a valid/ready handshake.
- Decouples processor output bursts from consumer stalls.
- Flags lost values with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 16, width of one output word (matches processor datapath).
- DEPTH, 8, number of FIFO entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_write  input  1  push strobe, one word per high cycle (driven by the processor output-enable).
- in_data  input  DATA_WIDTH  word to push; sampled when in_write=1.
- in_ready  input  1  consumer ready.
- in_clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- out_valid  output  1  out_data holds a valid head word.
- out_data  output  DATA_WIDTH  head-of-FIFO word.
- out_full  output  1  count==DEPTH.
- out_empty  output  1  count==0.
- out_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- out_overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset is asynchronous on RST low. All of the following hold while RST=0 and are released on the first rising CLK edge after RST=1:
  - wr_ptr=0, rd_ptr=0, count=0
  - out_valid=0, out_data=0
  - out_empty=1, out_full=0, out_overflow=0
  - Storage contents are don't-care.
- Push accepted when in_write=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - mem[wr_ptr]<=in_data.
  - wr_ptr wraps modulo DEPTH.
- Pop occurs when out_valid=1 and in_ready=1; rd_ptr increments and wraps modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including at full (push is accepted there) and at count==1.
- Latency: a word pushed into an empty FIFO appears on out_data with out_valid=1 on the next cycle. There is no same-cycle bypass.
- Output is first-word-fall-through:
  - out_data always reflects mem[rd_ptr] when out_valid=1.
  - out_data is stable while out_valid=1 and in_ready=0.
- out_valid = (count!=0), registered alongside count.
- Dropped push: in_write=1 at count==DEPTH with no pop.
  - Word discarded; pointers and count unchanged.
  - out_overflow<=1 next cycle.
- out_overflow stays 1 until in_clr_ovf=1. If clear and a new drop coincide, the set wins.
- A push in the same cycle as an async reset assertion is lost; no partial state is retained.
- out_full and out_empty are derived from the registered count, so they are glitch-free.
- No combinational path from in_write/in_data to any output.

Optional Feature:
- Macro OUTPUT_PORT_FIFO_CHANGE_DETECT_EN.
- Defined:
  - Block keeps a last_pushed register (reset 0) plus a have_last flag (reset 0).
  - A push with in_write=1 is suppressed when have_last=1 and in_data==last_pushed. Repeated identical output values are filtered.
  - Suppressed pushes never set overflow.
  - last_pushed/have_last update only on accepted pushes.
- Undefined: every in_write=1 cycle is a push attempt, as described in Behaviour.

Decomposition:
- Shared package/include holds:
  - OUT_FIFO_DEFAULT_DEPTH=8
  - PROC_DATA_WIDTH=16
  - a localparam helper for ADDR_W.
- One natural sub-module, fifo_storage_ram: DEPTH x DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
- Pointer, count, handshake and overflow logic stay in output_port_fifo.

Test Plan:
- Reset mid-operation: push 0x1111, 0x2222, then pull RST low between clock edges → immediately out_valid=0, out_count=0, out_empty=1, out_overflow=0. After release, the next push 0x3333 appears as the head.
- Single push: in_write=1, in_data=0xBEEF for one cycle, in_ready=0 → next cycle out_valid=1, out_data=0xBEEF, out_count=1. Value holds until in_ready=1, then out_empty=1 one cycle later.
- Fill and overflow: 9 consecutive pushes 0x0001..0x0009 with in_ready=0 → out_full=1, out_count=8, out_overflow=1. Draining yields exactly 0x0001..0x0008 in order.
- Push+pop at full: full FIFO, in_write=1 (0x00AA) with in_ready=1 → count stays 8, no overflow. 0x00AA emerges last after draining.
- Wrap-around: 20 push/pop pairs of incrementing data with a constant occupancy of 3 → output sequence is exact and in order, with no loss or duplication across pointer wrap.
- Overflow clear race: overflow set, then in_clr_ovf=1 in the same cycle as another dropped push → out_overflow stays 1. A later clear with no drop → out_overflow=0.
- With OUTPUT_PORT_FIFO_CHANGE_DETECT_EN defined: pushes 0x0005, 0x0005, 0x0006 → out_count=2, output sequence 0x0005, 0x0006.

Source files
------------

// File: rtl/output_port_fifo_pkg.sv
// Shared constants for the processor output-port FIFO: default geometry and
// the pointer-width helper.
package output_port_fifo_pkg;

    localparam int OUT_FIFO_DEFAULT_DEPTH = 8;
    localparam int PROC_DATA_WIDTH        = 16;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int fifoAddrW(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/output_port_fifo_storage_ram.sv
// DEPTH x DATA_WIDTH register array with a synchronous write port and an
// asynchronous read port; contents are not reset.
module fifo_storage_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/output_port_fifo.sv
// Output-port FIFO between the processor output register and a slow consumer.
// Optional repeat-value filter enabled by OUTPUT_PORT_FIFO_CHANGE_DETECT_EN.
module output_port_fifo
    import output_port_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = PROC_DATA_WIDTH,
    parameter int  DEPTH      = OUT_FIFO_DEFAULT_DEPTH,
    localparam int ADDR_W     = fifoAddrW(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_write,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ready,
    input  logic                  in_clr_ovf,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_full,
    output logic                  out_empty,
    output logic [ADDR_W:0]       out_count,
    output logic                  out_overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]     wrPtr;
    logic [ADDR_W-1:0]     rdPtr;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] headWord;
    logic                  isFull;
    logic                  pushReq;
    logic                  push;
    logic                  pop;
    logic                  drop;

`ifdef OUTPUT_PORT_FIFO_CHANGE_DETECT_EN
    logic [DATA_WIDTH-1:0] lastPushed;
    logic                  haveLast;

    // A repeat of the last accepted word is not a push attempt at all,
    // so it can never be counted as a drop.
    assign pushReq = in_write && !(haveLast && (in_data == lastPushed));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lastPushed <= '0;
            haveLast   <= 1'b0;
        end else if (push) begin
            lastPushed <= in_data;
            haveLast   <= 1'b1;
        end
    end
`else
    assign pushReq = in_write;
`endif

    // Handshake: a word transfers on any rising edge where out_valid and
    // in_ready are both high; out_data is held stable while out_valid is high
    // and in_ready is low. A pop frees a slot in the same cycle, so a push at
    // full is accepted when it coincides with a pop.
    assign isFull = (count == FULL_COUNT);
    assign pop    = out_valid && in_ready;
    assign push   = pushReq && (!isFull || pop);
    assign drop   = pushReq && isFull && !pop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            // A fresh drop outranks a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (in_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    fifo_storage_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_storage (
        .clk  (CLK),
        .we   (push),
        .waddr(wrPtr),
        .wdata(in_data),
        .raddr(rdPtr),
        .rdata(headWord)
    );

    // All outputs come from registered state; the head word is masked so an
    // empty FIFO never shows stale storage.
    assign out_valid    = (count != '0);
    assign out_empty    = (count == '0);
    assign out_full     = isFull;
    assign out_count    = count;
    assign out_overflow = overflow;
    assign out_data     = out_valid ? headWord : '0;

endmodule

// File: tb/tb_output_port_fifo.sv
// Directed bench for output_port_fifo: scoreboard queue checked by a monitor
// on every accepted output word, plus direct status checks.
module tb_output_port_fifo;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_write = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready = 1'b0;
    logic          in_clr_ovf = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_full;
    logic          out_empty;
    logic [3:0]    out_count;
    logic          out_overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_q[$];

    output_port_fifo dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_write    (in_write),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .in_clr_ovf  (in_clr_ovf),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_full    (out_full),
        .out_empty   (out_empty),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic push_word(input logic [DW-1:0] d, input bit accepted);
        in_write = 1'b1;
        in_data  = d;
        if (accepted) exp_q.push_back(d);
        tick();
        in_write = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_empty) begin
                done = 1'b1;
                break;
            end
        end
        in_ready = 1'b0;
        check("drain_reaches_empty", {31'b0, done}, 32'd1);
        check("drain_queue_used_up", exp_q.size(), 0);
    endtask

    // scoreboard monitor: compares each word at the negedge before it transfers
    always @(negedge CLK) begin
        if (RST && out_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL out_word_unexpected: got 0x%0h, expected none", out_data);
            end else begin
                check("out_word", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // reset state
        #2 RST = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", out_count, 0);
        check("rst_empty", out_empty, 1);
        check("rst_full", out_full, 0);
        check("rst_ovf", out_overflow, 0);
        #20 RST = 1'b1;
        tick();

        // reset mid-operation
        push_word(16'h1111, 1'b1);
        push_word(16'h2222, 1'b1);
        check("pre_rst_count", out_count, 2);
        #2 RST = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_count", out_count, 0);
        check("midrst_empty", out_empty, 1);
        check("midrst_ovf", out_overflow, 0);
        exp_q.delete();
        @(negedge CLK) RST = 1'b1;
        tick();
        push_word(16'h3333, 1'b1);
        check("after_rst_valid", out_valid, 1);
        check("after_rst_head", out_data, 16'h3333);
        check("after_rst_count", out_count, 1);
        drain();

        // single push, held until ready
        push_word(16'hBEEF, 1'b1);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 16'hBEEF);
        check("single_count", out_count, 1);
        tick(); tick(); tick();
        check("single_hold", out_data, 16'hBEEF);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("single_empty", out_empty, 1);

        // fill and overflow
        for (int i = 1; i <= 9; i++) push_word(DW'(i), i <= 8);
        check("fill_full", out_full, 1);
        check("fill_count", out_count, 8);
        check("fill_ovf", out_overflow, 1);

        // clear racing a new drop: set wins
        in_clr_ovf = 1'b1;
        in_write = 1'b1;
        in_data = 16'h00FF;
        tick();
        in_write = 1'b0;
        check("race_ovf_kept", out_overflow, 1);
        check("race_count", out_count, 8);
        tick();
        in_clr_ovf = 1'b0;
        check("clear_ovf", out_overflow, 0);

        // push + pop at full
        in_write = 1'b1;
        in_data = 16'h00AA;
        in_ready = 1'b1;
        exp_q.push_back(16'h00AA);
        tick();
        in_write = 1'b0;
        in_ready = 1'b0;
        check("pushpop_full_count", out_count, 8);
        check("pushpop_full_ovf", out_overflow, 0);
        drain();

        // wrap-around at constant occupancy 3
        for (int k = 0; k < 3; k++) push_word(DW'(16'h0100 + k), 1'b1);
        for (int k = 3; k < 23; k++) begin
            in_write = 1'b1;
            in_data = DW'(16'h0100 + k);
            in_ready = 1'b1;
            exp_q.push_back(DW'(16'h0100 + k));
            tick();
            check("wrap_count", out_count, 3);
        end
        in_write = 1'b0;
        in_ready = 1'b0;
        drain();

`ifdef OUTPUT_PORT_FIFO_CHANGE_DETECT_EN
        // repeated values filtered
        push_word(16'h0005, 1'b1);
        push_word(16'h0005, 1'b0);
        push_word(16'h0006, 1'b1);
        check("cd_count", out_count, 2);
        check("cd_ovf", out_overflow, 0);
        drain();
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
